// File: rtl/alu_pkg.sv
// Shared ALU opcode and condition-code encodings.
// Used by the ALU, its condition evaluator and the decoder.
package alu_pkg;

  localparam logic [3:0] OP_ALU_ADD     = 4'd0;
  localparam logic [3:0] OP_ALU_SUB     = 4'd1;
  localparam logic [3:0] OP_ALU_AND     = 4'd2;
  localparam logic [3:0] OP_ALU_OR      = 4'd3;
  localparam logic [3:0] OP_ALU_XOR     = 4'd4;
  localparam logic [3:0] OP_ALU_NOT     = 4'd5;
  localparam logic [3:0] OP_ALU_COMPARE = 4'd6;

  localparam logic [3:0] OP_CONDITION_ZERO_EQUAL                = 4'd0;
  localparam logic [3:0] OP_CONDITION_NOT_ZERO_NOT_EQUAL        = 4'd1;
  localparam logic [3:0] OP_CONDITION_UNSIGNED_GREATER_OR_EQUAL = 4'd2;
  localparam logic [3:0] OP_CONDITION_UNSIGNED_LESS             = 4'd3;
  localparam logic [3:0] OP_CONDITION_NEGATIVE                  = 4'd4;
  localparam logic [3:0] OP_CONDITION_POSITIVE                  = 4'd5;
  localparam logic [3:0] OP_CONDITION_OVERFLOW                  = 4'd6;
  localparam logic [3:0] OP_CONDITION_NO_OVERFLOW               = 4'd7;
  localparam logic [3:0] OP_CONDITION_UNSIGNED_GREATER          = 4'd8;
  localparam logic [3:0] OP_CONDITION_UNSIGNED_LESS_OR_EQUAL    = 4'd9;
  localparam logic [3:0] OP_CONDITION_SIGNED_GREATER_OR_EQUAL   = 4'd10;
  localparam logic [3:0] OP_CONDITION_SIGNED_LESS               = 4'd11;
  localparam logic [3:0] OP_CONDITION_SIGNED_GREATER            = 4'd12;
  localparam logic [3:0] OP_CONDITION_SIGNED_LESS_OR_EQUAL      = 4'd13;
  localparam logic [3:0] OP_CONDITION_ALWAYS                    = 4'd14;
  localparam logic [3:0] OP_CONDITION_NEVER                     = 4'd15;

  // Bit positions inside the {zero, overflow, sign, carry} image.
  localparam int FLAG_Z = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_condition.sv
// Condition evaluator: registered flags + condition code -> holds.
// Ports: flags {z,o,s,c}, condition code in, condition_holds out.
module alu_condition
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] condition,
  output logic       condition_holds
);

  logic z, o, s, c;

  always_comb begin
    z = flags[FLAG_Z];
    o = flags[FLAG_O];
    s = flags[FLAG_S];
    c = flags[FLAG_C];
    condition_holds = 1'b0;
    case (condition)
      OP_CONDITION_ZERO_EQUAL:
        condition_holds = z;
      OP_CONDITION_NOT_ZERO_NOT_EQUAL:
        condition_holds = !z;
      OP_CONDITION_UNSIGNED_GREATER_OR_EQUAL:
        condition_holds = c;
      OP_CONDITION_UNSIGNED_LESS:
        condition_holds = !c;
      OP_CONDITION_NEGATIVE:
        condition_holds = s;
      OP_CONDITION_POSITIVE:
        condition_holds = !s;
      OP_CONDITION_OVERFLOW:
        condition_holds = o;
      OP_CONDITION_NO_OVERFLOW:
        condition_holds = !o;
      OP_CONDITION_UNSIGNED_GREATER:
        condition_holds = c & !z;
      OP_CONDITION_UNSIGNED_LESS_OR_EQUAL:
        condition_holds = !c | z;
      OP_CONDITION_SIGNED_GREATER_OR_EQUAL:
        condition_holds = (s == o);
      OP_CONDITION_SIGNED_LESS:
        condition_holds = (s != o);
      OP_CONDITION_SIGNED_GREATER:
        condition_holds = !z & (s == o);
      OP_CONDITION_SIGNED_LESS_OR_EQUAL:
        condition_holds = z | (s != o);
      OP_CONDITION_ALWAYS:
        condition_holds = 1'b1;
      default:
        condition_holds = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// ALU with combinational result and a registered {z,o,s,c} flag set.
// Ports: clk/reset, aluA/aluB/func in, aluOut out, condition ->
// conditionHolds, updateFlags/loadFlagsFromSavedState/savedFlags, flags.
module alu
  import alu_pkg::*;
#(
  parameter int dataBits = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [dataBits-1:0] aluA,
  input  logic [dataBits-1:0] aluB,
  input  logic [3:0]          func,
  input  logic [3:0]          condition,
  input  logic                updateFlags,
  input  logic                loadFlagsFromSavedState,
  input  logic [3:0]          savedFlags,
  output logic [dataBits-1:0] aluOut,
  output logic                conditionHolds,
  output logic [3:0]          flags
);

  localparam int MSB = dataBits - 1;

  logic [dataBits:0]   sum;
  logic [dataBits:0]   diff;
  logic [dataBits-1:0] result;
  logic                next_c;
  logic                next_o;
  logic [3:0]          next_flags;
  logic [3:0]          flags_d;
  logic [3:0]          flags_q;

  // Subtraction as A + ~B + 1 so bit dataBits is "no borrow".
  assign sum  = {1'b0, aluA} + {1'b0, aluB};
  assign diff = {1'b0, aluA} + {1'b0, ~aluB} + {{dataBits{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    next_c = 1'b0;
    next_o = 1'b0;
    case (func)
      OP_ALU_ADD: begin
        result = sum[MSB:0];
        next_c = sum[dataBits];
        next_o = (aluA[MSB] == aluB[MSB])
               & (sum[MSB] != aluA[MSB]);
      end
      OP_ALU_SUB, OP_ALU_COMPARE: begin
        result = diff[MSB:0];
        next_c = diff[dataBits];
        next_o = (aluA[MSB] != aluB[MSB])
               & (diff[MSB] != aluA[MSB]);
      end
      OP_ALU_AND: result = aluA & aluB;
      OP_ALU_OR:  result = aluA | aluB;
      OP_ALU_XOR: result = aluA ^ aluB;
      OP_ALU_NOT: result = ~aluA;
      default:    result = '0;
    endcase
  end

  always_comb begin
    next_flags         = '0;
    next_flags[FLAG_Z] = (result == '0);
    next_flags[FLAG_O] = next_o;
    next_flags[FLAG_S] = result[MSB];
    next_flags[FLAG_C] = next_c;
  end

  always_comb begin
    flags_d = flags_q;
    if (reset)
      flags_d = '0;
    else if (loadFlagsFromSavedState)
      flags_d = savedFlags;
    else if (updateFlags)
      flags_d = next_flags;
  end

  always_ff @(posedge clk) begin
    flags_q <= flags_d;
  end

  assign aluOut = result;
  assign flags  = flags_q;

  alu_condition u_cond (
    .flags           (flags_q),
    .condition       (condition),
    .condition_holds (conditionHolds)
  );

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (dataBits = 8).
// Immediate assertions against hand-computed expected values.
module tb_alu;
  import alu_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] aluA;
  logic [7:0] aluB;
  logic [3:0] func;
  logic [3:0] condition;
  logic       updateFlags;
  logic       loadFlagsFromSavedState;
  logic [3:0] savedFlags;
  logic [7:0] aluOut;
  logic       conditionHolds;
  logic [3:0] flags;

  int n_chk;
  int n_fail;

  alu #(.dataBits(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .aluA                    (aluA),
    .aluB                    (aluB),
    .func                    (func),
    .condition               (condition),
    .updateFlags             (updateFlags),
    .loadFlagsFromSavedState (loadFlagsFromSavedState),
    .savedFlags              (savedFlags),
    .aluOut                  (aluOut),
    .conditionHolds          (conditionHolds),
    .flags                   (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply an operation and pulse updateFlags for one edge.
  task automatic op_upd(input logic [3:0] f,
                        input logic [7:0] a,
                        input logic [7:0] b);
    func = f;
    aluA = a;
    aluB = b;
    updateFlags = 1'b1;
    @(posedge clk);
    #1;
    updateFlags = 1'b0;
  endtask

  task automatic cond(input string tag,
                      input logic [3:0] cc,
                      input logic exp);
    condition = cc;
    #1;
    chk(tag, {31'd0, conditionHolds}, {31'd0, exp});
  endtask

  task automatic res(input string tag,
                     input logic [3:0] f,
                     input logic [7:0] exp);
    func = f;
    #1;
    chk(tag, {24'd0, aluOut}, {24'd0, exp});
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    aluA = 8'd0;
    aluB = 8'd0;
    func = OP_ALU_ADD;
    condition = OP_CONDITION_ALWAYS;
    updateFlags = 1'b0;
    loadFlagsFromSavedState = 1'b0;
    savedFlags = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state; aluOut live during reset
    chk("rst_flags", {28'd0, flags}, 32'd0);
    aluA = 8'd3;
    aluB = 8'd4;
    res("rst_aluout", OP_ALU_ADD, 8'd7);
    reset = 1'b0;
    cond("rst_ne", OP_CONDITION_NOT_ZERO_NOT_EQUAL, 1'b1);
    cond("rst_ult", OP_CONDITION_UNSIGNED_LESS, 1'b1);
    cond("rst_pos", OP_CONDITION_POSITIVE, 1'b1);
    cond("rst_nov", OP_CONDITION_NO_OVERFLOW, 1'b1);
    cond("rst_alw", OP_CONDITION_ALWAYS, 1'b1);
    cond("rst_eq", OP_CONDITION_ZERO_EQUAL, 1'b0);

    // Results for A=116, B=12
    aluA = 8'd116;
    aluB = 8'd12;
    res("add", OP_ALU_ADD, 8'd128);
    res("sub", OP_ALU_SUB, 8'd104);
    res("not", OP_ALU_NOT, 8'd139);
    res("or", OP_ALU_OR, 8'd124);
    res("and", OP_ALU_AND, 8'd4);
    res("xor", OP_ALU_XOR, 8'd120);
    res("cmp", OP_ALU_COMPARE, 8'd104);
    res("rsv9", 4'd9, 8'd0);
    res("rsv15", 4'd15, 8'd0);
    aluA = 8'd200;
    aluB = 8'd100;
    res("add_wrap", OP_ALU_ADD, 8'd44);

    // Flag latency: nothing changes before the edge
    func = OP_ALU_COMPARE;
    aluA = 8'd255;
    aluB = 8'd255;
    updateFlags = 1'b1;
    cond("eq_pre", OP_CONDITION_ZERO_EQUAL, 1'b0);
    updateFlags = 1'b0;

    // COMPARE basics
    op_upd(OP_ALU_COMPARE, 8'd255, 8'd255);
    cond("eq_255", OP_CONDITION_ZERO_EQUAL, 1'b1);
    chk("fl_255", {28'd0, flags}, 32'd9);
    op_upd(OP_ALU_COMPARE, 8'd255, 8'd254);
    cond("ne_254", OP_CONDITION_NOT_ZERO_NOT_EQUAL, 1'b1);
    op_upd(OP_ALU_COMPARE, 8'd0, 8'd1);
    cond("neg_0_1", OP_CONDITION_NEGATIVE, 1'b1);
    chk("fl_0_1", {28'd0, flags}, 32'd2);
    op_upd(OP_ALU_COMPARE, 8'd2, 8'd1);
    cond("neg_2_1", OP_CONDITION_NEGATIVE, 1'b0);

    // Unsigned
    op_upd(OP_ALU_COMPARE, 8'd225, 8'd31);
    cond("ugt_225", OP_CONDITION_UNSIGNED_GREATER, 1'b1);
    op_upd(OP_ALU_COMPARE, 8'd31, 8'd225);
    cond("ugt_31", OP_CONDITION_UNSIGNED_GREATER, 1'b0);
    op_upd(OP_ALU_COMPARE, 8'd126, 8'd126);
    cond("ule_126", OP_CONDITION_UNSIGNED_LESS_OR_EQUAL, 1'b1);
    cond("ult_126", OP_CONDITION_UNSIGNED_LESS, 1'b0);
    cond("uge_126", OP_CONDITION_UNSIGNED_GREATER_OR_EQUAL, 1'b1);

    // Signed
    op_upd(OP_ALU_COMPARE, 8'd128, 8'd127);
    cond("sle_128", OP_CONDITION_SIGNED_LESS_OR_EQUAL, 1'b1);
    chk("fl_128", {28'd0, flags}, 32'd5);
    op_upd(OP_ALU_COMPARE, 8'd175, 8'd150);
    cond("sgt_175", OP_CONDITION_SIGNED_GREATER, 1'b1);
    op_upd(OP_ALU_COMPARE, 8'd200, 8'd10);
    cond("slt_200", OP_CONDITION_SIGNED_LESS, 1'b1);
    op_upd(OP_ALU_COMPARE, 8'd130, 8'd150);
    cond("sge_130", OP_CONDITION_SIGNED_GREATER_OR_EQUAL, 1'b0);

    // ADD overflow / carry
    op_upd(OP_ALU_ADD, 8'd127, 8'd127);
    cond("ov_127", OP_CONDITION_OVERFLOW, 1'b1);
    cond("nov_127", OP_CONDITION_NO_OVERFLOW, 1'b0);
    chk("fl_127", {28'd0, flags}, 32'd6);
    op_upd(OP_ALU_ADD, 8'd10, 8'd10);
    cond("ov_10", OP_CONDITION_OVERFLOW, 1'b0);
    cond("always", OP_CONDITION_ALWAYS, 1'b1);
    cond("never", OP_CONDITION_NEVER, 1'b0);
    op_upd(OP_ALU_ADD, 8'd200, 8'd100);
    chk("fl_carry", {28'd0, flags}, 32'd1);
    op_upd(OP_ALU_XOR, 8'd255, 8'd0);
    chk("fl_logic", {28'd0, flags}, 32'd2);

    // Saved flags win over update
    func = OP_ALU_ADD;
    aluA = 8'd10;
    aluB = 8'd10;
    savedFlags = 4'b1000;
    loadFlagsFromSavedState = 1'b1;
    updateFlags = 1'b1;
    @(posedge clk);
    #1;
    loadFlagsFromSavedState = 1'b0;
    updateFlags = 1'b0;
    cond("load_eq", OP_CONDITION_ZERO_EQUAL, 1'b1);
    chk("load_fl", {28'd0, flags}, 32'd8);

    // Reset clears even with load/update asserted
    reset = 1'b1;
    loadFlagsFromSavedState = 1'b1;
    updateFlags = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    loadFlagsFromSavedState = 1'b0;
    updateFlags = 1'b0;
    cond("rst2_eq", OP_CONDITION_ZERO_EQUAL, 1'b0);
    chk("rst2_fl", {28'd0, flags}, 32'd0);

    // Hold across operand changes
    op_upd(OP_ALU_SUB, 8'd5, 8'd5);
    aluA = 8'd1;
    aluB = 8'd2;
    func = OP_ALU_ADD;
    @(posedge clk);
    @(posedge clk);
    #1;
    cond("hold_eq", OP_CONDITION_ZERO_EQUAL, 1'b1);
    chk("hold_fl", {28'd0, flags}, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
